// File: rtl/prefix_collector_if.sv
// Byte stream into the prefix collector and the opcode/prefix bundle out of it.
// master = prefetch queue + decoder side, slave = the collector itself.
interface prefix_collector_if #(
    parameter int CNT_W = 4
);
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_opcode;
    logic             out_address_size;
    logic             out_operand_size;
    logic             out_bus_lock;
    logic             out_rep;
    logic             out_repne;
    logic             out_segment_override;
    logic [2:0]       out_segment_override_index;
    logic [CNT_W-1:0] out_prefix_count;
    logic             out_fault_too_long;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_valid, out_opcode, out_address_size, out_operand_size,
               out_bus_lock, out_rep, out_repne, out_segment_override,
               out_segment_override_index, out_prefix_count, out_fault_too_long
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_valid, out_opcode, out_address_size, out_operand_size,
               out_bus_lock, out_rep, out_repne, out_segment_override,
               out_segment_override_index, out_prefix_count, out_fault_too_long
    );
endinterface

// File: rtl/prefix_collector.sv
// Accumulates x86 prefix bytes and hands the first non-prefix byte plus the
// collected prefix bundle to the decoder; faults when the prefix run is too long.
module prefix_collector #(
    parameter int MAX_PREFIX = 14,
    parameter int CNT_W      = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    prefix_collector_if.slave   bus,
    output logic                o_dbg_state
);
    // Handshakes: a byte moves when in_valid & in_ready, a bundle moves when
    // out_valid & out_ready; both sides are sampled on the rising clock edge.

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    // Segment register encoding: ES=0 CS=1 SS=2 DS=3 FS=4 GS=5
    localparam logic [2:0] SEG_ES = 3'd0;
    localparam logic [2:0] SEG_CS = 3'd1;
    localparam logic [2:0] SEG_SS = 3'd2;
    localparam logic [2:0] SEG_DS = 3'd3;
    localparam logic [2:0] SEG_FS = 3'd4;
    localparam logic [2:0] SEG_GS = 3'd5;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [7:0]       r_opcode;
    logic             r_addr_size;
    logic             r_op_size;
    logic             r_lock;
    logic             r_rep;
    logic             r_repne;
    logic             r_seg;
    logic [2:0]       r_seg_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_fault;

    logic             w_is_prefix;
    logic             w_is_seg;
    logic [2:0]       w_seg_idx;
    logic             w_byte_xfer;
    logic             w_at_limit;

    always_comb begin
        w_is_prefix = 1'b1;
        w_is_seg    = 1'b1;
        w_seg_idx   = SEG_ES;
        case (bus.in_byte)
            8'h26: w_seg_idx = SEG_ES;
            8'h2E: w_seg_idx = SEG_CS;
            8'h36: w_seg_idx = SEG_SS;
            8'h3E: w_seg_idx = SEG_DS;
            8'h64: w_seg_idx = SEG_FS;
            8'h65: w_seg_idx = SEG_GS;
            8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3: w_is_seg = 1'b0;
            default: begin
                w_is_prefix = 1'b0;
                w_is_seg    = 1'b0;
            end
        endcase
    end

    assign w_byte_xfer = bus.in_valid && r_in_ready;
    assign w_at_limit  = (r_count == CNT_W'(MAX_PREFIX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_opcode    <= 8'h00;
            r_addr_size <= 1'b0;
            r_op_size   <= 1'b0;
            r_lock      <= 1'b0;
            r_rep       <= 1'b0;
            r_repne     <= 1'b0;
            r_seg       <= 1'b0;
            r_seg_idx   <= 3'd0;
            r_count     <= '0;
            r_fault     <= 1'b0;
        end else if (flush || (r_state == HOLD && bus.out_ready)) begin
            // flush discards whatever else happens this cycle; a completed
            // output transfer returns to the same idle state
            r_state     <= COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_opcode    <= 8'h00;
            r_addr_size <= 1'b0;
            r_op_size   <= 1'b0;
            r_lock      <= 1'b0;
            r_rep       <= 1'b0;
            r_repne     <= 1'b0;
            r_seg       <= 1'b0;
            r_seg_idx   <= 3'd0;
            r_count     <= '0;
            r_fault     <= 1'b0;
        end else if (r_state == COLLECT && w_byte_xfer) begin
            if (!w_is_prefix) begin
                r_opcode    <= bus.in_byte;
                r_state     <= HOLD;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
            end else if (w_at_limit) begin
                // one prefix too many: the offending byte leaves flags/count untouched
                r_fault     <= 1'b1;
                r_state     <= HOLD;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                if (w_is_seg) begin
                    r_seg     <= 1'b1;
                    r_seg_idx <= w_seg_idx;
                end
                case (bus.in_byte)
                    8'h66: r_op_size   <= 1'b1;
                    8'h67: r_addr_size <= 1'b1;
                    8'hF0: r_lock      <= 1'b1;
                    8'hF2: begin
                        r_repne <= 1'b1;
                        r_rep   <= 1'b0;
                    end
                    8'hF3: begin
                        r_rep   <= 1'b1;
                        r_repne <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready                   = r_in_ready;
    assign bus.out_valid                  = r_out_valid;
    assign bus.out_opcode                 = r_opcode;
    assign bus.out_address_size           = r_addr_size;
    assign bus.out_operand_size           = r_op_size;
    assign bus.out_bus_lock               = r_lock;
    assign bus.out_rep                    = r_rep;
    assign bus.out_repne                  = r_repne;
    assign bus.out_segment_override      = r_seg;
    assign bus.out_segment_override_index = r_seg_idx;
    assign bus.out_prefix_count           = r_count;
    assign bus.out_fault_too_long         = r_fault;
    assign o_dbg_state                    = r_state;
endmodule

// File: tb/tb_prefix_collector.sv
// Directed bench for prefix_collector: hand-computed bundles checked with
// immediate assertions after each step.
module tb_prefix_collector;
    logic clock;
    logic reset;
    logic flush;
    logic dbg_state;
    int   n_tests;
    int   n_fail;

    prefix_collector_if #(.CNT_W(4)) bus ();

    prefix_collector #(.MAX_PREFIX(14), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {in_ready, out_valid, opcode, addr, opsz, lock, rep, repne, seg, idx, count, fault}
    function automatic logic [23:0] obs_vec();
        return {bus.in_ready, bus.out_valid, bus.out_opcode, bus.out_address_size,
                bus.out_operand_size, bus.out_bus_lock, bus.out_rep, bus.out_repne,
                bus.out_segment_override, bus.out_segment_override_index,
                bus.out_prefix_count, bus.out_fault_too_long};
    endfunction

    function automatic logic [23:0] exp_vec(input logic rdy, input logic vld, input logic [7:0] opc,
                                            input logic addr, input logic opsz, input logic lock,
                                            input logic rep, input logic repne, input logic seg,
                                            input logic [2:0] idx, input logic [3:0] cnt,
                                            input logic fault);
        return {rdy, vld, opc, addr, opsz, lock, rep, repne, seg, idx, cnt, fault};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic take();
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
    endtask

    logic [23:0] idle_v;

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        idle_v = exp_vec(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset_state", 32'(obs_vec()), 32'(idle_v));
        check("reset_dbg_state", 32'(dbg_state), 32'd0);

        // zero-prefix instruction
        send_byte(8'h90);
        check("nop_bundle", 32'(obs_vec()), 32'(exp_vec(0, 1, 8'h90, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0)));
        take();
        check("nop_release", 32'(obs_vec()), 32'(idle_v));

        // operand size + two segments, FS wins
        send_byte(8'h66);
        send_byte(8'h2E);
        send_byte(8'h64);
        check("seg_mid_count", 32'(bus.out_prefix_count), 32'd3);
        send_byte(8'h8B);
        check("seg_bundle", 32'(obs_vec()), 32'(exp_vec(0, 1, 8'h8B, 0, 1, 0, 0, 0, 1, 3'd4, 4'd3, 0)));
        take();
        check("seg_release", 32'(obs_vec()), 32'(idle_v));

        // F3 then F2: repne wins; stall downstream for 5 cycles with bytes offered
        send_byte(8'hF3);
        send_byte(8'hF2);
        send_byte(8'hA4);
        @(negedge clock);
        bus.in_byte  = 8'h66;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("rep_hold_%0d", i), 32'(obs_vec()),
                  32'(exp_vec(0, 1, 8'hA4, 0, 0, 0, 0, 1, 0, 3'd0, 4'd2, 0)));
        end
        bus.in_valid = 1'b0;
        take();
        check("rep_release", 32'(obs_vec()), 32'(idle_v));

        // prefix length limit
        for (int i = 0; i < 14; i++) send_byte(8'h66);
        check("limit_14_count", 32'(bus.out_prefix_count), 32'd14);
        check("limit_14_valid", 32'(bus.out_valid), 32'd0);
        send_byte(8'h66);
        check("limit_fault", 32'(bus.out_fault_too_long), 32'd1);
        check("limit_count_sat", 32'(bus.out_prefix_count), 32'd14);
        check("limit_valid", 32'(bus.out_valid), 32'd1);
        check("limit_in_ready", 32'(bus.in_ready), 32'd0);
        take();
        check("limit_release", 32'(obs_vec()), 32'(idle_v));

        // flush discards collected prefixes and the byte offered with it
        send_byte(8'hF0);
        send_byte(8'h67);
        @(negedge clock);
        flush        = 1'b1;
        bus.in_byte  = 8'h01;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_cleared", 32'(obs_vec()), 32'(idle_v));
        send_byte(8'h90);
        check("flush_next", 32'(obs_vec()), 32'(exp_vec(0, 1, 8'h90, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0)));
        take();

        // mixed: F2, ES, F3, GS -> rep wins, GS index, count 4
        send_byte(8'hF2);
        send_byte(8'h26);
        send_byte(8'hF3);
        send_byte(8'h65);
        send_byte(8'h00);
        check("mixed_bundle", 32'(obs_vec()), 32'(exp_vec(0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 3'd5, 4'd4, 0)));
        check("mixed_dbg_state", 32'(dbg_state), 32'd1);

        // asynchronous reset while holding a bundle
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(obs_vec()), 32'(idle_v));
        #1;
        reset = 1'b0;
        send_byte(8'h90);
        check("after_reset", 32'(obs_vec()), 32'(exp_vec(0, 1, 8'h90, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0)));
        take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prefix_collector.md
Name: prefix_collector

Overview:
- Sits between the instruction prefetch queue and the opcode decoder, consuming one instruction byte per cycle.
- Classifies each byte as prefix or non-prefix and accumulates prefix state across any number of consecutive prefix bytes.
- On the first non-prefix byte, presents the opcode byte plus the accumulated prefix bundle to the opcode/ModRM decode stage over a valid/ready handshake.
- Enforces the architectural prefix-length limit.

Parameters:
- MAX_PREFIX, 14: maximum prefix bytes accepted per instruction before a length fault is raised.
- CNT_W, 4: width of the prefix counter; must satisfy 2^CNT_W > MAX_PREFIX.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of the partially collected instruction (branch/exception).
- in_byte  input  8  next instruction byte from prefetch queue.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  collector accepts in_byte this cycle.
- out_valid  output  1  opcode and prefix bundle valid.
- out_ready  input  1  downstream decoder accepts bundle.
- out_opcode  output  8  first non-prefix byte.
- out_address_size  output  1  0x67 seen.
- out_operand_size  output  1  0x66 seen.
- out_bus_lock  output  1  0xF0 seen.
- out_rep  output  1  0xF3 is the last REP-class prefix.
- out_repne  output  1  0xF2 is the last REP-class prefix.
- out_segment_override  output  1  any segment prefix seen.
- out_segment_override_index  output  3  index_reg_seg__ encoding of the last segment prefix; 0 when none.
- out_prefix_count  output  CNT_W  number of prefix bytes consumed.
- out_fault_too_long  output  1  prefix limit exceeded; out_opcode is don't-care.

Behaviour:
- Reset (async, reset=1): state=COLLECT; all outputs 0 except in_ready=1; all accumulators cleared.
- Byte transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Prefix bytes: 0x26, 0x2E, 0x36, 0x3E, 0x64, 0x65, 0x66, 0x67, 0xF0, 0xF2, 0xF3. Every other value is non-prefix.
- State COLLECT: in_ready=1, out_valid=0.
  - Prefix transfer: set the matching flag; increment count.
  - Segment prefix: last one wins; the index is overwritten with CS/DS/ES/FS/GS/SS as decoded.
  - F2/F3: last one wins; the other of out_rep/out_repne is cleared.
  - Repeated 66/67/F0 are legal; the flag stays 1 and count still increments.
  - Non-prefix transfer: latch out_opcode; move to HOLD. out_valid=1 the following cycle, so latency from opcode byte to out_valid is one cycle.
  - Prefix transfer while count==MAX_PREFIX: do not increment; set out_fault_too_long; move to HOLD.
- State HOLD: in_ready=0, out_valid=1. All out_* stable until the output transfer.
  - On output transfer: clear flags, index, count and fault; return to COLLECT. in_ready=1 the next cycle; no bypass.
- flush=1 (any state): next cycle COLLECT with everything cleared.
  - Any byte or output transfer in the flush cycle is discarded.
  - flush takes priority over all other events.
- Reset mid-instruction: immediate clear, identical to the reset values.
- out_prefix_count saturates at MAX_PREFIX and never wraps.
- Zero-prefix instruction: count=0 and all flags 0 at out_valid.

Test Plan:
- Reset, then in_byte=0x90 with in_valid=1 → cycle+1: out_valid=1, out_opcode=0x90, count=0, all flags 0, in_ready=0.
- Bytes 0x66, 0x2E, 0x64, 0x8B → out_operand_size=1, out_segment_override=1, index=index_reg_seg__FS (last wins), count=3, out_opcode=0x8B.
- Bytes 0xF3, 0xF2, 0xA4 with out_ready held 0 for 5 cycles → out_repne=1, out_rep=0; outputs stable and in_ready=0 throughout; one cycle after out_ready=1, in_ready=1 and all flags clear.
- 15 consecutive 0x66 bytes → after the 15th, out_fault_too_long=1, count=14, out_valid=1.
- Bytes 0xF0, 0x67, then flush=1 together with 0x01 valid → 0x01 not consumed; next 0x90 yields count=0, bus_lock=0, address_size=0.
- Assert reset asynchronously mid-HOLD (between clock edges) → out_valid=0 and in_ready=1 immediately, all flags 0.
